// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the cache-side memory port arbiter: FSM state
// encodings, request type codes, owner encoding and a line-compare helper.
package cache_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_WAIT = 2'd2
    } rd_state_t;

    typedef enum logic {
        W_EMPTY = 1'b0,
        W_FULL  = 1'b1
    } wr_state_t;

    localparam logic [2:0] TYPE_BYTE = 3'b000;
    localparam logic [2:0] TYPE_HALF = 3'b001;
    localparam logic [2:0] TYPE_WORD = 3'b010;
    localparam logic [2:0] TYPE_LINE = 3'b100;

    typedef enum logic {
        OWNER_ICACHE = 1'b0,
        OWNER_DCACHE = 1'b1
    } owner_t;

    // True when both addresses fall in the same 16-byte cache line.
    function automatic logic same_line(input logic [ADDR_W-1:0] a,
                                       input logic [ADDR_W-1:0] b);
        return a[ADDR_W-1:4] == b[ADDR_W-1:4];
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of every handshake between the two caches, the arbiter and the
// AXI bridge. The arbiter uses the slave view; the surrounding system
// (caches plus bridge) uses the master view.
interface cache_mem_arbiter_if;
    import cache_bus_pkg::*;

    logic              i_rd_req;
    logic [2:0]        i_rd_type;
    logic [ADDR_W-1:0] i_rd_addr;
    logic              i_rd_rdy;
    logic              i_ret_valid;
    logic              i_ret_last;
    logic [DATA_W-1:0] i_ret_data;

    logic              d_rd_req;
    logic [2:0]        d_rd_type;
    logic [ADDR_W-1:0] d_rd_addr;
    logic              d_rd_rdy;
    logic              d_ret_valid;
    logic              d_ret_last;
    logic [DATA_W-1:0] d_ret_data;

    logic              d_wr_req;
    logic [2:0]        d_wr_type;
    logic [ADDR_W-1:0] d_wr_addr;
    logic [3:0]        d_wr_wstrb;
    logic [LINE_W-1:0] d_wr_data;
    logic              d_wr_rdy;

    logic              m_rd_req;
    logic [2:0]        m_rd_type;
    logic [ADDR_W-1:0] m_rd_addr;
    logic              m_rd_rdy;
    logic              m_ret_valid;
    logic              m_ret_last;
    logic [DATA_W-1:0] m_ret_data;

    logic              m_wr_req;
    logic [2:0]        m_wr_type;
    logic [ADDR_W-1:0] m_wr_addr;
    logic [3:0]        m_wr_wstrb;
    logic [LINE_W-1:0] m_wr_data;
    logic              m_wr_rdy;

    modport slave (
        input  i_rd_req, i_rd_type, i_rd_addr,
        output i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
        input  d_rd_req, d_rd_type, d_rd_addr,
        output d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
        input  d_wr_req, d_wr_type, d_wr_addr, d_wr_wstrb, d_wr_data,
        output d_wr_rdy,
        output m_rd_req, m_rd_type, m_rd_addr,
        input  m_rd_rdy, m_ret_valid, m_ret_last, m_ret_data,
        output m_wr_req, m_wr_type, m_wr_addr, m_wr_wstrb, m_wr_data,
        input  m_wr_rdy
    );

    modport master (
        output i_rd_req, i_rd_type, i_rd_addr,
        input  i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
        output d_rd_req, d_rd_type, d_rd_addr,
        input  d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
        output d_wr_req, d_wr_type, d_wr_addr, d_wr_wstrb, d_wr_data,
        input  d_wr_rdy,
        input  m_rd_req, m_rd_type, m_rd_addr,
        output m_rd_rdy, m_ret_valid, m_ret_last, m_ret_data,
        input  m_wr_req, m_wr_type, m_wr_addr, m_wr_wstrb, m_wr_data,
        output m_wr_rdy
    );

endinterface

// File: rtl/cache_mem_arbiter_line_wr_buffer.sv
// One-entry data-cache write-back buffer. Holds a full line write until the
// bridge takes it; exposes its occupancy and address for read hazard checks.
module line_wr_buffer
    import cache_bus_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_req,
    input  logic [2:0]        wr_type,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_wstrb,
    input  logic [LINE_W-1:0] wr_data,
    output logic              wr_rdy,
    output logic              m_wr_req,
    output logic [2:0]        m_wr_type,
    output logic [ADDR_W-1:0] m_wr_addr,
    output logic [3:0]        m_wr_wstrb,
    output logic [LINE_W-1:0] m_wr_data,
    input  logic              m_wr_rdy,
    output logic              full,
    output logic [ADDR_W-1:0] line_addr
);

    wr_state_t         state_reg, state_next;
    logic              rdy_reg;
    logic              capture;
    logic [2:0]        type_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [3:0]        wstrb_reg;
    logic [LINE_W-1:0] data_reg;

    // Fill when empty and ready; drain when the bridge accepts. The drain
    // cycle cannot also fill, because ready only reflects the settled state.
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        case (state_reg)
            W_EMPTY: if (wr_req && rdy_reg) begin
                capture    = 1'b1;
                state_next = W_FULL;
            end
            W_FULL:  if (m_wr_rdy) state_next = W_EMPTY;
            default: state_next = W_EMPTY;
        endcase
    end

    // State, registered ready flag and captured write fields.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= W_EMPTY;
            rdy_reg   <= 1'b0;
            type_reg  <= '0;
            addr_reg  <= '0;
            wstrb_reg <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            rdy_reg   <= (state_next == W_EMPTY);
            if (capture) begin
                type_reg  <= wr_type;
                addr_reg  <= wr_addr;
                wstrb_reg <= wr_wstrb;
                data_reg  <= wr_data;
            end
        end
    end

    assign wr_rdy     = rdy_reg;
    assign full       = (state_reg == W_FULL);
    assign m_wr_req   = full;
    assign m_wr_type  = type_reg;
    assign m_wr_addr  = addr_reg;
    assign m_wr_wstrb = wstrb_reg;
    assign m_wr_data  = data_reg;
    assign line_addr  = addr_reg;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the bridge read port between icache and dcache (round-robin, one
// outstanding read), steers return beats to the owner, and routes dcache
// write-backs through a one-entry line buffer with read-after-write guard.
module cache_mem_arbiter
    import cache_bus_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    cache_mem_arbiter_if.slave bus
);

    rd_state_t         rd_state_reg, rd_state_next;
    owner_t            owner_reg, owner_next;
    owner_t            last_reg, last_next;
    logic [2:0]        type_reg, type_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              grant_i, grant_d;
    logic              i_elig, d_elig;
    logic              buf_full;
    logic [ADDR_W-1:0] buf_addr;
    logic              fwd_i, fwd_d;

    line_wr_buffer u_wr_buf (
        .clk        (clk),
        .resetn     (resetn),
        .wr_req     (bus.d_wr_req),
        .wr_type    (bus.d_wr_type),
        .wr_addr    (bus.d_wr_addr),
        .wr_wstrb   (bus.d_wr_wstrb),
        .wr_data    (bus.d_wr_data),
        .wr_rdy     (bus.d_wr_rdy),
        .m_wr_req   (bus.m_wr_req),
        .m_wr_type  (bus.m_wr_type),
        .m_wr_addr  (bus.m_wr_addr),
        .m_wr_wstrb (bus.m_wr_wstrb),
        .m_wr_data  (bus.m_wr_data),
        .m_wr_rdy   (bus.m_wr_rdy),
        .full       (buf_full),
        .line_addr  (buf_addr)
    );

    // A read to the line sitting in the write buffer must wait for the drain;
    // nothing is granted while reset is held so every ready stays low.
    assign i_elig = resetn && bus.i_rd_req && !(buf_full && same_line(bus.i_rd_addr, buf_addr));
    assign d_elig = resetn && bus.d_rd_req && !(buf_full && same_line(bus.d_rd_addr, buf_addr));

    // Read FSM: round-robin grant in idle, hold request until accepted,
    // then forward beats until the last one.
    always_comb begin
        rd_state_next = rd_state_reg;
        owner_next    = owner_reg;
        last_next     = last_reg;
        type_next     = type_reg;
        addr_next     = addr_reg;
        grant_i       = 1'b0;
        grant_d       = 1'b0;
        case (rd_state_reg)
            R_IDLE: begin
                if (d_elig && (!i_elig || last_reg == OWNER_ICACHE)) grant_d = 1'b1;
                else if (i_elig)                                    grant_i = 1'b1;
                if (grant_d) begin
                    owner_next    = OWNER_DCACHE;
                    last_next     = OWNER_DCACHE;
                    type_next     = bus.d_rd_type;
                    addr_next     = bus.d_rd_addr;
                    rd_state_next = R_REQ;
                end else if (grant_i) begin
                    owner_next    = OWNER_ICACHE;
                    last_next     = OWNER_ICACHE;
                    type_next     = bus.i_rd_type;
                    addr_next     = bus.i_rd_addr;
                    rd_state_next = R_REQ;
                end
            end
            R_REQ:   if (bus.m_rd_rdy) rd_state_next = R_WAIT;
            R_WAIT:  if (bus.m_ret_valid && bus.m_ret_last) rd_state_next = R_IDLE;
            default: rd_state_next = R_IDLE;
        endcase
    end

    // Read FSM state, owner, round-robin pointer and latched request fields.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state_reg <= R_IDLE;
            owner_reg    <= OWNER_ICACHE;
            last_reg     <= OWNER_ICACHE;
            type_reg     <= '0;
            addr_reg     <= '0;
        end else begin
            rd_state_reg <= rd_state_next;
            owner_reg    <= owner_next;
            last_reg     <= last_next;
            type_reg     <= type_next;
            addr_reg     <= addr_next;
        end
    end

    assign fwd_i = (rd_state_reg == R_WAIT) && bus.m_ret_valid && (owner_reg == OWNER_ICACHE);
    assign fwd_d = (rd_state_reg == R_WAIT) && bus.m_ret_valid && (owner_reg == OWNER_DCACHE);

    assign bus.i_rd_rdy    = grant_i;
    assign bus.d_rd_rdy    = grant_d;
    assign bus.i_ret_valid = fwd_i;
    assign bus.i_ret_last  = fwd_i && bus.m_ret_last;
    assign bus.i_ret_data  = fwd_i ? bus.m_ret_data : '0;
    assign bus.d_ret_valid = fwd_d;
    assign bus.d_ret_last  = fwd_d && bus.m_ret_last;
    assign bus.d_ret_data  = fwd_d ? bus.m_ret_data : '0;
    assign bus.m_rd_req    = (rd_state_reg == R_REQ);
    assign bus.m_rd_type   = type_reg;
    assign bus.m_rd_addr   = addr_reg;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench: a transaction-level model of the arbiter predicts
// every output each cycle; directed scenarios add literal expectations,
// then a long randomized run exercises ties, hazards, stalls and resets.
module tb_cache_mem_arbiter;
    import cache_bus_pkg::*;

    logic clk;
    logic resetn;
    cache_mem_arbiter_if bus();

    cache_mem_arbiter dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: one outstanding read (phase 0 free, 1 waiting for bridge accept,
    // 2 receiving beats) and an optional buffered write.
    int          ph;
    bit          own_d;
    bit          last_d;
    logic [31:0] rd_addr_m;
    logic [2:0]  rd_type_m;
    bit          b_full;
    bit          armed;
    logic [31:0] b_addr;
    logic [2:0]  b_type;
    logic [3:0]  b_strb;
    logic [127:0] b_data;
    bit          gi, gd;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        ph = 0; own_d = 0; last_d = 0;
        rd_addr_m = '0; rd_type_m = '0;
        b_full = 0; armed = 0;
        b_addr = '0; b_type = '0; b_strb = '0; b_data = '0;
    endtask

    // Settle, then compare every DUT output against the model.
    task automatic cyc();
        bit ie, de, fi, fd;
        #1;
        if (!resetn) model_reset();
        ie = resetn && bus.i_rd_req && !(b_full && bus.i_rd_addr[31:4] == b_addr[31:4]);
        de = resetn && bus.d_rd_req && !(b_full && bus.d_rd_addr[31:4] == b_addr[31:4]);
        gi = (ph == 0) && ie && (!de || last_d);
        gd = (ph == 0) && de && !gi;
        fi = (ph == 2) && bus.m_ret_valid && !own_d;
        fd = (ph == 2) && bus.m_ret_valid && own_d;
        chk("i_rd_rdy",    bus.i_rd_rdy,    gi);
        chk("d_rd_rdy",    bus.d_rd_rdy,    gd);
        chk("i_ret_valid", bus.i_ret_valid, fi);
        chk("i_ret_last",  bus.i_ret_last,  fi && bus.m_ret_last);
        chk("i_ret_data",  bus.i_ret_data,  fi ? bus.m_ret_data : 32'h0);
        chk("d_ret_valid", bus.d_ret_valid, fd);
        chk("d_ret_last",  bus.d_ret_last,  fd && bus.m_ret_last);
        chk("d_ret_data",  bus.d_ret_data,  fd ? bus.m_ret_data : 32'h0);
        chk("d_wr_rdy",    bus.d_wr_rdy,    armed && !b_full);
        chk("m_rd_req",    bus.m_rd_req,    ph == 1);
        chk("m_rd_type",   bus.m_rd_type,   rd_type_m);
        chk("m_rd_addr",   bus.m_rd_addr,   rd_addr_m);
        chk("m_wr_req",    bus.m_wr_req,    b_full);
        chk("m_wr_type",   bus.m_wr_type,   b_type);
        chk("m_wr_addr",   bus.m_wr_addr,   b_addr);
        chk("m_wr_wstrb",  bus.m_wr_wstrb,  b_strb);
        chk("m_wr_data",   bus.m_wr_data,   b_data);
    endtask

    // Apply this cycle's clock edge to the model, then move to the next cycle.
    task automatic tick();
        if (resetn) begin
            if (b_full) begin
                if (bus.m_wr_rdy) b_full = 0;
            end else if (armed && bus.d_wr_req) begin
                b_full = 1;
                b_addr = bus.d_wr_addr; b_type = bus.d_wr_type;
                b_strb = bus.d_wr_wstrb; b_data = bus.d_wr_data;
                $display("wr buffered addr=%h type=%0d strb=%h", b_addr, b_type, b_strb);
            end
            armed = 1;
            case (ph)
                0: if (gi || gd) begin
                    own_d  = gd;
                    last_d = gd;
                    rd_addr_m = gd ? bus.d_rd_addr : bus.i_rd_addr;
                    rd_type_m = gd ? bus.d_rd_type : bus.i_rd_type;
                    ph = 1;
                    $display("rd grant %s addr=%h type=%0d", gd ? "dcache" : "icache", rd_addr_m, rd_type_m);
                end
                1: if (bus.m_rd_rdy) ph = 2;
                default: if (bus.m_ret_valid && bus.m_ret_last) ph = 0;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic step();
        cyc();
        tick();
    endtask

    // From a granted-but-unissued read: accept, then deliver four beats.
    task automatic finish_read();
        bus.m_rd_rdy = 1; step(); bus.m_rd_rdy = 0;
        for (int k = 0; k < 4; k++) begin
            bus.m_ret_valid = 1; bus.m_ret_last = (k == 3); bus.m_ret_data = $urandom;
            step();
        end
        bus.m_ret_valid = 0; bus.m_ret_last = 0;
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 3))
            0: return 32'h2000_0010;
            1: return 32'h2000_001C;
            2: return 32'h3000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [2:0] pick_type();
        case ($urandom_range(0, 3))
            0: return TYPE_BYTE;
            1: return TYPE_HALF;
            2: return TYPE_WORD;
            default: return TYPE_LINE;
        endcase
    endfunction

    initial begin
        clk = 0; resetn = 0;
        bus.i_rd_req = 0; bus.i_rd_type = '0; bus.i_rd_addr = '0;
        bus.d_rd_req = 0; bus.d_rd_type = '0; bus.d_rd_addr = '0;
        bus.d_wr_req = 0; bus.d_wr_type = '0; bus.d_wr_addr = '0;
        bus.d_wr_wstrb = '0; bus.d_wr_data = '0;
        bus.m_rd_rdy = 0; bus.m_ret_valid = 0; bus.m_ret_last = 0; bus.m_ret_data = '0;
        bus.m_wr_rdy = 0;
        model_reset();

        // Reset state.
        @(negedge clk);
        cyc(); chk("rst d_wr_rdy", bus.d_wr_rdy, 1'b0); tick();
        resetn = 1;
        step();
        cyc(); chk("post-rst d_wr_rdy", bus.d_wr_rdy, 1'b1); tick();

        // Single icache line read with a stalled bridge accept.
        bus.i_rd_req = 1; bus.i_rd_type = TYPE_LINE; bus.i_rd_addr = 32'h1000_0040;
        cyc(); chk("ic grant", bus.i_rd_rdy, 1'b1); tick();
        bus.i_rd_req = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("stall m_rd_req", bus.m_rd_req, 1'b1);
            chk("stall m_rd_addr", bus.m_rd_addr, 32'h1000_0040);
            tick();
        end
        bus.m_rd_rdy = 1; step(); bus.m_rd_rdy = 0;
        for (int k = 0; k < 4; k++) begin
            bus.m_ret_valid = 1; bus.m_ret_last = (k == 3); bus.m_ret_data = 32'hA000_0000 + k;
            cyc();
            chk("beat i_ret_valid", bus.i_ret_valid, 1'b1);
            chk("beat d_ret_valid", bus.d_ret_valid, 1'b0);
            chk("beat i_ret_last", bus.i_ret_last, (k == 3));
            chk("beat i_ret_data", bus.i_ret_data, 32'hA000_0000 + k);
            tick();
        end
        bus.m_ret_valid = 0; bus.m_ret_last = 0;

        // Ties: dcache, then icache, then dcache.
        bus.i_rd_req = 1; bus.i_rd_addr = 32'h1000_0100;
        bus.d_rd_req = 1; bus.d_rd_type = TYPE_LINE; bus.d_rd_addr = 32'h4000_0200;
        for (int t = 0; t < 3; t++) begin
            cyc();
            chk("tie d_rd_rdy", bus.d_rd_rdy, (t != 1));
            chk("tie i_rd_rdy", bus.i_rd_rdy, (t == 1));
            tick();
            finish_read();
        end
        bus.i_rd_req = 0; bus.d_rd_req = 0;

        // Write-back buffered, read to the same line held off.
        bus.d_wr_req = 1; bus.d_wr_type = TYPE_LINE; bus.d_wr_addr = 32'h2000_0010;
        bus.d_wr_wstrb = 4'hF; bus.d_wr_data = {4{32'h5A5A_0000}};
        cyc(); chk("wr rdy", bus.d_wr_rdy, 1'b1); tick();
        bus.d_wr_req = 0;
        bus.d_rd_req = 1; bus.d_rd_addr = 32'h2000_001C;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("hazard d_rd_rdy", bus.d_rd_rdy, 1'b0);
            chk("held m_wr_addr", bus.m_wr_addr, 32'h2000_0010);
            tick();
        end
        // Other-line read proceeds alongside the pending write.
        bus.i_rd_req = 1; bus.i_rd_addr = 32'h3000_0000;
        cyc(); chk("nohaz i_rd_rdy", bus.i_rd_rdy, 1'b1); tick();
        bus.i_rd_req = 0;
        cyc();
        chk("both m_rd_req", bus.m_rd_req, 1'b1);
        chk("both m_wr_req", bus.m_wr_req, 1'b1);
        chk("both m_rd_addr", bus.m_rd_addr, 32'h3000_0000);
        tick();
        finish_read();
        bus.m_wr_rdy = 1;
        cyc(); chk("drain d_rd_rdy", bus.d_rd_rdy, 1'b0); tick();
        bus.m_wr_rdy = 0;
        cyc(); chk("after drain d_rd_rdy", bus.d_rd_rdy, 1'b1); tick();
        bus.d_rd_req = 0;
        finish_read();

        // Reset in the middle of a burst.
        bus.i_rd_req = 1; bus.i_rd_addr = 32'h1000_0080;
        step(); bus.i_rd_req = 0;
        bus.m_rd_rdy = 1; step(); bus.m_rd_rdy = 0;
        for (int k = 0; k < 2; k++) begin
            bus.m_ret_valid = 1; bus.m_ret_last = 0; bus.m_ret_data = 32'hB000_0000 + k;
            step();
        end
        resetn = 0;
        cyc();
        chk("mid-rst i_ret_valid", bus.i_ret_valid, 1'b0);
        chk("mid-rst m_rd_addr", bus.m_rd_addr, 32'h0);
        chk("mid-rst d_wr_rdy", bus.d_wr_rdy, 1'b0);
        tick();
        resetn = 1;
        cyc(); chk("stray beat3", bus.i_ret_valid, 1'b0); tick();
        bus.m_ret_last = 1;
        cyc();
        chk("stray beat4", bus.i_ret_valid, 1'b0);
        chk("rel d_wr_rdy", bus.d_wr_rdy, 1'b1);
        tick();
        bus.m_ret_valid = 0; bus.m_ret_last = 0;

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            resetn         = ($urandom_range(0, 199) != 0);
            bus.i_rd_req   = ($urandom_range(0, 2) != 0);
            bus.i_rd_addr  = pick_addr();
            bus.i_rd_type  = pick_type();
            bus.d_rd_req   = ($urandom_range(0, 2) != 0);
            bus.d_rd_addr  = pick_addr();
            bus.d_rd_type  = pick_type();
            bus.d_wr_req   = ($urandom_range(0, 2) == 0);
            bus.d_wr_addr  = pick_addr();
            bus.d_wr_type  = pick_type();
            bus.d_wr_wstrb = 4'($urandom);
            bus.d_wr_data  = {$urandom, $urandom, $urandom, $urandom};
            bus.m_rd_rdy   = ($urandom_range(0, 2) == 0);
            bus.m_ret_valid = ($urandom_range(0, 1) == 0);
            bus.m_ret_last = ($urandom_range(0, 3) == 0);
            bus.m_ret_data = $urandom;
            bus.m_wr_rdy   = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
